rv32i_axi_dmem_slave: RTL and testbench
=======================================

Name: rv32i_axi_dmem_slave

Overview:
AXI4-Lite slave data memory that terminates the core's AXI4-Lite data port. It is the direct downstream consumer of the core-side AXI master bridge. It holds a word-organised, byte-strobed RAM. Write (AW/W/B) and read (AR/R) paths are independent, each with one outstanding transaction, and programmable read wait states let the bench exercise master stall behaviour.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words (power of two, ≥4)
BASE_ADDR, 32'h0001_0000, byte address of word 0 (aligned to DEPTH_WORDS*4)
RD_WAIT, 0, extra cycles between AR handshake and RVALID (0..15)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
s_axi_awaddr  in  32  write byte address
s_axi_awprot  in  3  ignored
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte strobes, bit i → wdata[8i+7:8i]
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  32  read byte address
s_axi_arprot  in  3  ignored
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready

Behaviour:
- Reset (rst_n low, async): all readies 0, bvalid/rvalid 0, bresp/rresp 2'b00, rdata 0, both FSMs idle. RAM contents are not reset. Readies are registered and go to 1 on the first clock edge after rst_n rises.
- Word index = (addr − BASE_ADDR)[IDX_W+1:2], IDX_W = log2(DEPTH_WORDS). addr[1:0] is ignored.
- Write FSM states:
  - WR_IDLE: awready = !aw_held, wready = !w_held. AW and W are captured independently in any order or in the same cycle. Each ready drops the cycle after its handshake.
  - WR_IDLE→WR_RESP when both are held: the RAM is written with wstrb on that edge; strb=0 writes nothing but still responds OKAY. bvalid = 1 the next cycle, so B comes 1 cycle after the later of AW/W.
  - WR_RESP: hold bvalid and bresp until bready. On the handshake edge, bvalid→0, clear held flags, readies→1, go to WR_IDLE.
- Read FSM states:
  - RD_IDLE: arready = 1. On AR handshake, capture the address, arready→0, load wait counter = RD_WAIT, go to RD_WAIT (skip to RD_DATA if RD_WAIT = 0).
  - RD_WAIT: decrement each cycle; go to RD_DATA at 0.
  - On entry to RD_DATA the RAM word is sampled into rdata and rvalid→1. Read latency = RD_WAIT+1 cycles after the AR handshake.
  - RD_DATA: hold rdata, rresp and rvalid until rready. On handshake, rvalid→0, arready→1, go to RD_IDLE.
- Simultaneous write commit and read sample of the same word on one edge: the read returns the old data (read-before-write).
- Master holding bready/rready low stalls only that channel; the other path continues.
- Reset mid-transaction abandons it; no response is issued after reset.

Optional Feature:
RV32I_AXI_DMEM_RANGE_CHK_EN
- Defined: any address outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4) gets SLVERR (2'b10). An erroring write does not modify the RAM; an erroring read returns rdata = 32'h0 with rresp = SLVERR.
- Undefined: no check. The index wraps modulo DEPTH_WORDS, and bresp/rresp are always OKAY.

Decomposition:
- Package rv32i_axi_pkg:
  - response constants AXI_RESP_OKAY = 2'b00, AXI_RESP_SLVERR = 2'b10
  - wr_state_t {WR_IDLE, WR_RESP}
  - rd_state_t {RD_IDLE, RD_WAIT, RD_DATA}
- Sub-module rv32i_dmem_array: synchronous RAM with a 4-bit byte-enable write port and a registered read port, one of each. It is kept separate so the hardened design can swap in an SRAM macro.

Test Plan:
- AW and W in the same cycle, addr 0x0001_0010, data 0xDEADBEEF, strb 0xF → bvalid 1 cycle later with OKAY; read of 0x0001_0010 returns 0xDEADBEEF, rvalid 1 cycle after AR (RD_WAIT = 0).
- W 3 cycles before AW, strb 0x2, data 0x0000AB00, over word 0x11223344 → readback 0x1122AB44; B arrives only after AW.
- RD_WAIT = 5, bench holds rready low for 4 cycles → rvalid rises 6 cycles after AR; rdata stays stable and arready stays 0 until the handshake.
- Write commit and read sample of word 0x0001_0020 (old 0x1, new 0x2) on the same edge → read returns 0x1; a following read returns 0x2.
- RANGE_CHK_EN defined, write to 0x0002_0000 → bresp 2'b10 and the RAM is unchanged. Without the macro, 0x0001_1000 aliases word 0 and returns OKAY.
- rst_n pulsed low during RD_WAIT → rvalid stays 0; arready is 1 on the first edge after release and a new read completes normally.

Source files
------------

// File: rtl/rv32i_axi_pkg.sv
// Shared AXI4-Lite response codes and FSM state types for the data-memory slave.
package rv32i_axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic {
        WR_IDLE,
        WR_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_WAIT,
        RD_DATA
    } rd_state_t;

endpackage

// File: rtl/rv32i_dmem_array.sv
// Word-organised RAM: one byte-enabled write port, one registered read port.
// A read and a write to the same word on one edge return the old word.
module rv32i_dmem_array #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           we_i,
    input  logic [3:0]                     wstrb_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] waddr_i,
    input  logic [31:0]                    wdata_i,
    input  logic                           re_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] raddr_i,
    output logic [31:0]                    rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i && wstrb_i[b]) begin
                mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/rv32i_axi_dmem_slave.sv
// AXI4-Lite slave data memory with independent write and read paths, one outstanding each.
// Optional address range checking (SLVERR) is enabled by RV32I_AXI_DMEM_RANGE_CHK_EN.
module rv32i_axi_dmem_slave #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          RD_WAIT     = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] s_axi_awaddr,
    input  logic [2:0]  s_axi_awprot,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [31:0] s_axi_araddr,
    input  logic [2:0]  s_axi_arprot,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready
);

    import rv32i_axi_pkg::*;

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    // ---------------- write path state ----------------
    wr_state_t   wr_state_q;
    logic        aw_held_q, w_held_q;
    logic        awready_q, wready_q, bvalid_q;
    logic [1:0]  bresp_q;
    logic [31:0] awaddr_q, wdata_q;
    logic [3:0]  wstrb_q;

    logic        aw_hs, w_hs, wr_commit, wr_err;
    logic [31:0] waddr_d, wdata_d, woff;
    logic [3:0]  wstrb_d;

    // ---------------- read path state ----------------
    rd_state_t   rd_state_q;
    logic        arready_q, rvalid_q, rerr_q;
    logic [1:0]  rresp_q;
    logic [31:0] araddr_q;
    logic [3:0]  wait_cnt_q;

    logic        ar_hs, rd_sample, rd_err;
    logic [31:0] raddr_d, roff;
    logic [31:0] ram_rdata;

    assign aw_hs = s_axi_awvalid && awready_q;
    assign w_hs  = s_axi_wvalid  && wready_q;

    // A beat arriving this cycle is used directly so the commit lands on the handshake edge.
    assign waddr_d = aw_held_q ? awaddr_q : s_axi_awaddr;
    assign wdata_d = w_held_q  ? wdata_q  : s_axi_wdata;
    assign wstrb_d = w_held_q  ? wstrb_q  : s_axi_wstrb;
    assign woff    = waddr_d - BASE_ADDR;

    assign wr_commit = (wr_state_q == WR_IDLE)
                    && (aw_held_q || aw_hs)
                    && (w_held_q  || w_hs);

    assign ar_hs   = s_axi_arvalid && arready_q;
    assign raddr_d = (rd_state_q == RD_IDLE) ? s_axi_araddr : araddr_q;
    assign roff    = raddr_d - BASE_ADDR;

    assign rd_sample = ((rd_state_q == RD_IDLE) && ar_hs && (RD_WAIT == 0))
                    || ((rd_state_q == rv32i_axi_pkg::RD_WAIT) && (wait_cnt_q == 4'd0));

`ifdef RV32I_AXI_DMEM_RANGE_CHK_EN
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
    assign wr_err = (woff >= SPAN_BYTES);
    assign rd_err = (roff >= SPAN_BYTES);
`else
    assign wr_err = 1'b0;
    assign rd_err = 1'b0;
`endif

    logic unused_sig;
    assign unused_sig = ^{s_axi_awprot, s_axi_arprot,
                          woff[1:0], woff[31:IDX_W+2],
                          roff[1:0], roff[31:IDX_W+2]};

    rv32i_dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .we_i    (wr_commit && !wr_err),
        .wstrb_i (wstrb_d),
        .waddr_i (woff[IDX_W+1:2]),
        .wdata_i (wdata_d),
        .re_i    (rd_sample),
        .raddr_i (roff[IDX_W+1:2]),
        .rdata_o (ram_rdata)
    );

    // Write FSM: AW and W are accepted independently; B follows the later of the two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= WR_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= AXI_RESP_OKAY;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            unique case (wr_state_q)
                WR_IDLE: begin
                    if (aw_hs) begin
                        awaddr_q <= s_axi_awaddr;
                    end
                    if (w_hs) begin
                        wdata_q <= s_axi_wdata;
                        wstrb_q <= s_axi_wstrb;
                    end
                    if (wr_commit) begin
                        wr_state_q <= WR_RESP;
                        aw_held_q  <= 1'b1;
                        w_held_q   <= 1'b1;
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b0;
                        bvalid_q   <= 1'b1;
                        bresp_q    <= wr_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                    end else begin
                        aw_held_q  <= aw_held_q || aw_hs;
                        w_held_q   <= w_held_q  || w_hs;
                        awready_q  <= !(aw_held_q || aw_hs);
                        wready_q   <= !(w_held_q  || w_hs);
                    end
                end
                WR_RESP: begin
                    if (s_axi_bready) begin
                        wr_state_q <= WR_IDLE;
                        aw_held_q  <= 1'b0;
                        w_held_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wready_q   <= 1'b1;
                        bvalid_q   <= 1'b0;
                        bresp_q    <= AXI_RESP_OKAY;
                    end
                end
                default: wr_state_q <= WR_IDLE;
            endcase
        end
    end

    // Read FSM: the counter is preloaded one short because the sample edge itself is a wait cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rerr_q     <= 1'b0;
            rresp_q    <= AXI_RESP_OKAY;
            araddr_q   <= '0;
            wait_cnt_q <= '0;
        end else begin
            unique case (rd_state_q)
                RD_IDLE: begin
                    if (ar_hs) begin
                        araddr_q  <= s_axi_araddr;
                        arready_q <= 1'b0;
                        if (RD_WAIT == 0) begin
                            rd_state_q <= RD_DATA;
                            rvalid_q   <= 1'b1;
                            rerr_q     <= rd_err;
                            rresp_q    <= rd_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                        end else begin
                            rd_state_q <= rv32i_axi_pkg::RD_WAIT;
                            wait_cnt_q <= 4'(RD_WAIT - 1);
                        end
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                rv32i_axi_pkg::RD_WAIT: begin
                    if (wait_cnt_q == 4'd0) begin
                        rd_state_q <= RD_DATA;
                        rvalid_q   <= 1'b1;
                        rerr_q     <= rd_err;
                        rresp_q    <= rd_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                RD_DATA: begin
                    if (s_axi_rready) begin
                        rd_state_q <= RD_IDLE;
                        rvalid_q   <= 1'b0;
                        rerr_q     <= 1'b0;
                        rresp_q    <= AXI_RESP_OKAY;
                        arready_q  <= 1'b1;
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    // The array's read register holds the sampled word; gating keeps rdata at 0 outside a response.
    assign s_axi_rdata   = (rvalid_q && !rerr_q) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_rv32i_axi_dmem_slave.sv
// Scoreboard bench: two slaves (RD_WAIT 0 and 5) share the write channel; a memory model predicts responses.
module tb_rv32i_axi_dmem_slave;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          RDW   = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] s_axi_awaddr = '0, s_axi_wdata = '0, s_axi_araddr = '0, d5_araddr = '0;
    logic [2:0]  s_axi_awprot = '0, s_axi_arprot = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic s_axi_awvalid = 0, s_axi_wvalid = 0, s_axi_bready = 1, s_axi_arvalid = 0, s_axi_rready = 1;
    logic d5_arvalid = 0, d5_rready = 1;
    logic s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic [31:0] s_axi_rdata;
    logic d5_awready, d5_wready, d5_bvalid, d5_arready, d5_rvalid;
    logic [1:0]  d5_bresp, d5_rresp;
    logic [31:0] d5_rdata;

    rv32i_axi_dmem_slave #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .RD_WAIT(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr),
        .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready));

    rv32i_axi_dmem_slave #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .RD_WAIT(RDW)) dut5 (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(d5_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(d5_wready), .s_axi_bresp(d5_bresp),
        .s_axi_bvalid(d5_bvalid), .s_axi_bready(s_axi_bready), .s_axi_araddr(d5_araddr),
        .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(d5_arvalid), .s_axi_arready(d5_arready),
        .s_axi_rdata(d5_rdata), .s_axi_rresp(d5_rresp), .s_axi_rvalid(d5_rvalid),
        .s_axi_rready(d5_rready));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mem_m [int];

    function automatic int midx(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        return int'((o >> 2) & 32'(DEPTH - 1));
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
`ifdef RV32I_AXI_DMEM_RANGE_CHK_EN
        return ((a - BASE) < 32'(DEPTH * 4)) ? 2'b00 : 2'b10;
`else
        return (a === a) ? 2'b00 : 2'b00;
`endif
    endfunction

    function automatic logic [33:0] exp_read(input logic [31:0] a);
        logic [31:0] d;
        d = mem_m.exists(midx(a)) ? mem_m[midx(a)] : 32'h0;
        if (exp_resp(a) != 2'b00) d = 32'h0;
        return {exp_resp(a), d};
    endfunction

    task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        if (exp_resp(a) == 2'b00) begin
            w = mem_m.exists(midx(a)) ? mem_m[midx(a)] : 32'h0;
            for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
            mem_m[midx(a)] = w;
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [1:0]  bq[$];
    logic [33:0] rq[$], rq5[$];
    int bcnt = 0, rcnt = 0, r5cnt = 0;
    int cyc = 0, commit_cyc = 0, ar_cyc = 0, ar5_cyc = 0;
    logic pa = 0, pw = 0, ar5_pend = 0;
    logic [31:0] pa_addr, pw_data, ar5_addr, prev_rd5;
    logic [3:0]  pw_strb;
    logic prev_bv = 0, prev_rv = 0, prev_rv5 = 0, prev_rr5 = 0;
    logic [1:0]  e_b;
    logic [33:0] e_r;

    always @(negedge clk) begin
        if (!rst_n) begin
            pa = 0; pw = 0; ar5_pend = 0;
            bq.delete(); rq.delete(); rq5.delete();
            prev_bv = 0; prev_rv = 0; prev_rv5 = 0; prev_rr5 = 0;
        end else begin
            cyc++;
            if (s_axi_bvalid && !prev_bv) chk("b_latency", 64'(cyc), 64'(commit_cyc + 1));
            if (s_axi_rvalid && !prev_rv) chk("r_latency", 64'(cyc), 64'(ar_cyc + 1));
            if (d5_rvalid && !prev_rv5)   chk("r5_latency", 64'(cyc), 64'(ar5_cyc + RDW + 1));
            if (prev_rv5 && !prev_rr5) begin
                chk("r5_hold_valid", 64'(d5_rvalid), 64'd1);
                chk("r5_hold_data", 64'(d5_rdata), 64'(prev_rd5));
                chk("r5_arready_low", 64'(d5_arready), 64'd0);
            end
            if (s_axi_bvalid && s_axi_bready) begin
                if (bq.size() == 0) fail("b_unexpected");
                else begin
                    e_b = bq.pop_front();
                    chk("bresp", 64'(s_axi_bresp), 64'(e_b));
                    chk("b5_resp", 64'({d5_bvalid, d5_bresp}), 64'({1'b1, e_b}));
                end
                bcnt++;
            end
            if (s_axi_rvalid && s_axi_rready) begin
                if (rq.size() == 0) fail("r_unexpected");
                else begin
                    e_r = rq.pop_front();
                    chk("rresp_rdata", 64'({s_axi_rresp, s_axi_rdata}), 64'(e_r));
                end
                rcnt++;
            end
            if (d5_rvalid && d5_rready) begin
                if (rq5.size() == 0) fail("r5_unexpected");
                else begin
                    e_r = rq5.pop_front();
                    chk("r5resp_rdata", 64'({d5_rresp, d5_rdata}), 64'(e_r));
                end
                r5cnt++;
            end
            // Reads sampled on the coming edge see memory before any write committed on it.
            if (s_axi_arvalid && s_axi_arready) begin
                rq.push_back(exp_read(s_axi_araddr));
                ar_cyc = cyc;
            end
            if (d5_arvalid && d5_arready) begin
                ar5_addr = d5_araddr; ar5_cyc = cyc; ar5_pend = 1;
            end
            if (ar5_pend && cyc == ar5_cyc + RDW) begin
                rq5.push_back(exp_read(ar5_addr));
                ar5_pend = 0;
            end
            if (s_axi_awvalid && s_axi_awready) begin pa = 1; pa_addr = s_axi_awaddr; end
            if (s_axi_wvalid && s_axi_wready) begin pw = 1; pw_data = s_axi_wdata; pw_strb = s_axi_wstrb; end
            if (pa && pw) begin
                bq.push_back(exp_resp(pa_addr));
                mdl_write(pa_addr, pw_data, pw_strb);
                commit_cyc = cyc;
                pa = 0; pw = 0;
            end
            prev_bv = s_axi_bvalid; prev_rv = s_axi_rvalid;
            prev_rv5 = d5_rvalid; prev_rr5 = d5_rready; prev_rd5 = d5_rdata;
        end
    end

    // ---------------- drivers ----------------
    task automatic drive_aw(input logic [31:0] a);
        int n = 0;
        s_axi_awaddr = a; s_axi_awvalid = 1'b1;
        @(negedge clk);
        while (!s_axi_awready && n < 200) begin @(negedge clk); n++; end
        if (!s_axi_awready) fail("aw_timeout");
        @(posedge clk); #1 s_axi_awvalid = 1'b0;
    endtask

    task automatic drive_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
        @(negedge clk);
        while (!s_axi_wready && n < 200) begin @(negedge clk); n++; end
        if (!s_axi_wready) fail("w_timeout");
        @(posedge clk); #1 s_axi_wvalid = 1'b0;
    endtask

    task automatic drive_ar(input logic [31:0] a);
        int n = 0;
        s_axi_araddr = a; s_axi_arvalid = 1'b1;
        @(negedge clk);
        while (!s_axi_arready && n < 200) begin @(negedge clk); n++; end
        if (!s_axi_arready) fail("ar_timeout");
        @(posedge clk); #1 s_axi_arvalid = 1'b0;
    endtask

    task automatic drive_ar5(input logic [31:0] a);
        int n = 0;
        d5_araddr = a; d5_arvalid = 1'b1;
        @(negedge clk);
        while (!d5_arready && n < 200) begin @(negedge clk); n++; end
        if (!d5_arready) fail("ar5_timeout");
        @(posedge clk); #1 d5_arvalid = 1'b0;
    endtask

    task automatic wait_done(input int which, input int target);
        int n = 0;
        int c;
        c = (which == 0) ? bcnt : (which == 1) ? rcnt : r5cnt;
        while (c < target && n < 300) begin
            @(negedge clk); n++;
            c = (which == 0) ? bcnt : (which == 1) ? rcnt : r5cnt;
        end
        if (c < target) fail("response_timeout");
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly);
        int t;
        t = bcnt + 1;
        fork
            begin repeat (aw_dly) begin @(posedge clk); #1; end drive_aw(a); end
            begin repeat (w_dly)  begin @(posedge clk); #1; end drive_w(d, s); end
        join
        wait_done(0, t);
    endtask

    task automatic do_read(input logic [31:0] a);
        int t;
        t = rcnt + 1;
        drive_ar(a);
        wait_done(1, t);
    endtask

    task automatic do_read5(input logic [31:0] a);
        int t;
        t = r5cnt + 1;
        drive_ar5(a);
        wait_done(2, t);
    endtask

    logic rand_en = 0;
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_en) begin
                s_axi_bready = ($urandom_range(0, 3) != 0);
                s_axi_rready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    logic [31:0] a;
    logic        seen;
    int          n;

    initial begin
        #12;
        @(negedge clk);
        chk("rst_readies", 64'({s_axi_awready, s_axi_wready, s_axi_arready, d5_awready, d5_wready, d5_arready}), 64'd0);
        chk("rst_valids", 64'({s_axi_bvalid, s_axi_rvalid, d5_bvalid, d5_rvalid}), 64'd0);
        chk("rst_resp_data", 64'({s_axi_bresp, s_axi_rresp, s_axi_rdata}), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_before_edge", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'd0);
        @(negedge clk);
        chk("ready_after_edge", 64'({s_axi_awready, s_axi_wready, s_axi_arready, d5_arready}), 64'hF);
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) do_write(BASE + 32'(4 * i), $urandom, 4'hF, 0, 0);

        do_write(32'h0001_0010, 32'hDEAD_BEEF, 4'hF, 0, 0);
        do_read(32'h0001_0010);

        do_write(32'h0001_0014, 32'h1122_3344, 4'hF, 0, 0);
        do_write(32'h0001_0014, 32'h0000_AB00, 4'h2, 3, 0);
        do_read(32'h0001_0014);

        do_write(32'h0001_0020, 32'h1, 4'hF, 0, 0);
        fork
            do_write(32'h0001_0020, 32'h2, 4'hF, 0, 0);
            do_read(32'h0001_0020);
        join
        do_read(32'h0001_0020);

        do_write(32'h0001_1000, 32'hA5A5_0001, 4'hF, 0, 0);
        do_read(32'h0001_0000);
        do_write(32'h0002_0000, 32'h5A5A_0002, 4'hF, 0, 0);
        do_read(32'h0002_0000);
        do_read(32'h0001_0000);
        do_write(32'h0001_0008, 32'hFFFF_FFFF, 4'h0, 0, 0);
        do_read(32'h0001_0008);

        rand_en = 1;
        for (int k = 0; k < 80; k++) begin
            a = (($urandom_range(0, 7) == 0) ? 32'h0002_0000 : BASE)
              + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0: do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
                1: do_read(a);
                default: fork
                    do_write(a, $urandom, 4'hF, 0, $urandom_range(0, 2));
                    do_read(BASE + 32'(4 * $urandom_range(0, 15)));
                join
            endcase
        end
        rand_en = 0;
        @(posedge clk); #1 s_axi_bready = 1'b1; s_axi_rready = 1'b1;

        // Wait-state slave: stall R for 4 cycles after rvalid rises.
        d5_rready = 1'b0;
        drive_ar5(32'h0001_0010);
        n = 0;
        while (!d5_rvalid && n < 50) begin @(negedge clk); n++; end
        if (!d5_rvalid) fail("r5_valid_timeout");
        repeat (4) begin @(posedge clk); #1; end
        d5_rready = 1'b1;
        wait_done(2, 1);

        // Reset during the wait window abandons the read.
        drive_ar5(32'h0001_0014);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("ar5_ready_after_reset", 64'(d5_arready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin @(negedge clk); seen = seen | d5_rvalid; end
        chk("r5_no_resp_after_reset", 64'(seen), 64'd0);
        @(posedge clk); #1;
        do_read5(32'h0001_0014);
        do_read(32'h0001_0020);

        repeat (3) @(negedge clk);
        chk("b_queue_empty", 64'(bq.size()), 64'd0);
        chk("r_queue_empty", 64'(rq.size() + rq5.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
